vga_ball_field: RTL and testbench
=================================

# vga_ball_field

Parametrised multi-ball renderer for the VGA demo. It keeps the state of up to seven bouncing balls and updates them once per frame with a sequential update engine. It renders each pixel through a 2-stage pipeline that takes its inputs directly from `hvsync_generator` (`hpos`, `vpos`, `display_on`). The result is a 6-bit RGB value that the top level packs into `uo_out`.

## Interface
- `NUM_BALLS`, 4, number of balls; legal range 1..7
- `RADIUS`, 20, ball radius in pixels
- `SHADOW_W`, 4, shadow ring width in pixels
- `H_ACTIVE`, 640, visible width
- `V_ACTIVE`, 480, visible height

- `clk`  in  1  pixel clock; the only clock
- `reset`  in  1  reset, synchronous, active-high
- `frame_tick`  in  1  one-cycle pulse; must fall inside vertical blanking
- `pause`  in  1  1 = motion frozen
- `speed_sel`  in  2  step per frame = `speed_sel`+1 pixels
- `hpos`  in  10  current pixel x
- `vpos`  in  10  current pixel y
- `display_on`  in  1  visible-area flag
- `rgb`  out  6  {R[1:0],G[1:0],B[1:0]}
- `bounce`  out  1  one-cycle pulse per reflecting ball
- `busy`  out  1  update engine active

## Operation
- **Per-ball state:** x[9:0], y[9:0], xdir (1 = right), ydir (1 = down).
- **Reset values:**
  - ball i: x = 160+64·i, y = 120+48·i, xdir = ~i[0], ydir = ~i[1].
  - `rgb` = 0, `bounce` = 0, `busy` = 0; engine in IDLE.
- **Update engine states:** IDLE and UPDATE.
  - IDLE → UPDATE when `frame_tick` && !`pause`. Index k is cleared to 0 and the current `speed_sel` is latched as the step.
  - UPDATE processes ball k in one cycle, then k++. After ball NUM_BALLS−1 it returns to IDLE.
  - `frame_tick` while in UPDATE is ignored.
- **Per-axis step, x axis:**
  - Moving right: if x+step ≥ H_ACTIVE−1−RADIUS, then x = H_ACTIVE−1−RADIUS, xdir = 0, and the ball has reflected; else x += step.
  - Moving left: if x ≤ RADIUS+step, then x = RADIUS, xdir = 1, reflected; else x −= step.
  - The y axis works the same way with V_ACTIVE.
  - Compute in 11 bits so there is no wrap-around.
- **`bounce`:** pulses one cycle if either axis of the ball processed in the previous cycle reflected. A ball reflecting on both axes gives a single pulse.
- **Pixel pipeline:**
  - Stage 1: per ball, dx = hpos−x and dy = vpos−y as signed 11-bit; register d² = dx²+dy² (21 bits).
  - Stage 2: compare d² ≤ RADIUS² to get the ball hit. With shadow enabled, also d² ≤ (RADIUS+SHADOW_W)² to get the shadow hit.
  - `rgb` is registered with this priority:
    1. `display_on` = 0 → 0.
    2. Any ball hit → palette[lowest hit index].
    3. Any shadow hit → 6'b01_01_01.
    4. Otherwise background 6'b00_00_10.
  - `display_on` is delayed to match the pipeline.
- **Reset mid-update:** abandons the frame; all state returns to reset values on the next edge.

## Timing
- Pixel latency: exactly 2 clocks from `hpos`/`vpos`/`display_on` to `rgb`. The top level delays `hsync`/`vsync` by 2 to match.
- `busy` goes high the cycle after the accepted `frame_tick` and stays high for exactly NUM_BALLS cycles.
- Ball k's new position is visible to the pixel pipeline from cycle k+2 after the tick.
- `bounce` lags the reflecting update by 1 cycle.
- The whole update completes within 7 cycles, well inside vertical blanking. Mid-frame `frame_tick` is a caller error and may tear the image.

## Configuration
- Macro: `VGA_BALL_SHADOW_EN`.
- Defined: the shadow ring is rendered grey as described above.
- Undefined: the shadow compare and its logic are removed. Pixels inside the ring show background or lower-priority colour. `SHADOW_W` is unused.

## Structure
- Package `vga_ball_pkg` holds:
  - the palette of 7 six-bit colours: 11_10_00, 11_00_00, 00_11_00, 11_11_00, 00_11_11, 11_00_11, 11_11_11;
  - the shadow and background constants;
  - functions `init_x(i)` and `init_y(i)`.
- Sub-module `ball_axis_step` holds the one-axis step/clamp/reflect logic. It is instantiated twice, for x and y, and shared across balls by the engine.

## Test plan
- **Reset values:** Assert reset for 3 cycles, release → `rgb`=0, `busy`=0, `bounce`=0; ball0 = (160,120).
- **One update:** NUM_BALLS=4, `speed_sel`=1, single `frame_tick` → `busy` high 4 cycles; ball0 = (162,122); ball1 (xdir=0, ydir=1) = (222,170).
- **Pixel colour:** After reset, drive `hpos`=160, `vpos`=120, `display_on`=1 → `rgb`=11_10_00 two cycles later. With `display_on`=0 → `rgb`=0.
- **Shadow:** `hpos`=182, `vpos`=120 (d²=484) → 01_01_01 with `VGA_BALL_SHADOW_EN`, 00_00_10 without it.
- **Bounce:** NUM_BALLS=1, `speed_sel`=3, repeated ticks.
  - Frame 85: y clamps to 459, ydir=0, one `bounce` pulse.
  - Frame 115: x clamps to 619, xdir=0, one `bounce` pulse.
- **Pause:** `pause`=1 with `frame_tick` → `busy` stays 0 and positions are unchanged. A second `frame_tick` during `busy` → no extra update.

Source files
------------

// File: rtl/vga_ball_pkg.sv
// Shared types, colour constants and reset-position helpers for vga_ball_field.
package vga_ball_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } eng_state_e;

  localparam int          MAX_BALLS  = 7;
  localparam logic [5:0]  SHADOW_RGB = 6'b01_01_01;
  localparam logic [5:0]  BG_RGB     = 6'b00_00_10;

  function automatic logic [5:0] palette_rgb(input logic [2:0] idx);
    logic [5:0] c;
    case (idx)
      3'd0:    c = 6'b11_10_00;
      3'd1:    c = 6'b11_00_00;
      3'd2:    c = 6'b00_11_00;
      3'd3:    c = 6'b11_11_00;
      3'd4:    c = 6'b00_11_11;
      3'd5:    c = 6'b11_00_11;
      3'd6:    c = 6'b11_11_11;
      default: c = 6'b11_11_11;
    endcase
    return c;
  endfunction

  function automatic logic [9:0] init_x(input int i);
    return 10'(160 + 64 * i);
  endfunction

  function automatic logic [9:0] init_y(input int i);
    return 10'(120 + 48 * i);
  endfunction

  function automatic logic init_xdir(input int i);
    return ((i % 2) == 0);
  endfunction

  function automatic logic init_ydir(input int i);
    return (((i / 2) % 2) == 0);
  endfunction

  // Squared distance of a pixel from a ball centre; the sum of two squared
  // 11-bit signed deltas always fits in 21 bits.
  function automatic logic [20:0] dist2(input logic [9:0] px, input logic [9:0] py,
                                        input logic [9:0] bx, input logic [9:0] by);
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [21:0] sq;
    dx = {1'b0, px} - {1'b0, bx};
    dy = {1'b0, py} - {1'b0, by};
    sq = dx * dx + dy * dy;
    return 21'(sq);
  endfunction

endpackage

// File: rtl/vga_ball_field_ball_axis_step.sv
// One-axis step/clamp/reflect for a single ball coordinate; 11-bit math avoids wrap-around.
module ball_axis_step
  import vga_ball_pkg::*;
#(
  parameter int LIMIT  = 640,
  parameter int RADIUS = 20
) (
  input  logic [9:0] pos,
  input  logic       dir,
  input  logic [2:0] step,
  output logic [9:0] pos_next,
  output logic       dir_next,
  output logic       reflect
);

  localparam logic [9:0] HI = 10'(LIMIT - 1 - RADIUS);
  localparam logic [9:0] LO = 10'(RADIUS);

  logic [10:0] pos_w;
  logic [10:0] step_w;

  always_comb begin
    pos_w    = {1'b0, pos};
    step_w   = {8'd0, step};
    pos_next = pos;
    dir_next = dir;
    reflect  = 1'b0;
    if (dir) begin
      if (pos_w + step_w >= {1'b0, HI}) begin
        pos_next = HI;
        dir_next = 1'b0;
        reflect  = 1'b1;
      end else begin
        pos_next = 10'(pos_w + step_w);
      end
    end else begin
      if (pos_w <= {1'b0, LO} + step_w) begin
        pos_next = LO;
        dir_next = 1'b1;
        reflect  = 1'b1;
      end else begin
        pos_next = 10'(pos_w - step_w);
      end
    end
  end

endmodule

// File: rtl/vga_ball_field.sv
// Multi-ball renderer: per-frame sequential update engine plus a 2-stage pixel pipeline.
// Optional grey shadow ring around each ball is built when VGA_BALL_SHADOW_EN is defined.
module vga_ball_field
  import vga_ball_pkg::*;
#(
  parameter int NUM_BALLS = 4,
  parameter int RADIUS    = 20,
  parameter int SHADOW_W  = 4,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic [1:0] speed_sel,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  output logic [5:0] rgb,
  output logic       bounce,
  output logic       busy
);

  localparam logic [2:0]  LAST_K = 3'(NUM_BALLS - 1);
  localparam logic [20:0] R2     = 21'(RADIUS * RADIUS);

  if (NUM_BALLS < 1 || NUM_BALLS > MAX_BALLS || SHADOW_W < 0) begin : g_bad_cfg
    $error("vga_ball_field: illegal NUM_BALLS or SHADOW_W");
  end

  eng_state_e                state_q, state_d;
  logic [2:0]                k_q, k_d;
  logic [2:0]                step_q, step_d;
  logic [NUM_BALLS-1:0][9:0] x_q, x_d, y_q, y_d;
  logic [NUM_BALLS-1:0]      xdir_q, xdir_d, ydir_q, ydir_d;
  logic                      bounce_q, bounce_d;
  logic                      busy_q, busy_d;

  logic [9:0] cur_x, cur_y, nx, ny;
  logic       cur_xdir, cur_ydir, nxdir, nydir, refl_x, refl_y;

  // The single pair of axis units is time-shared: ball k_q is routed in by an AND-OR mux.
  always_comb begin
    cur_x    = 10'd0;
    cur_y    = 10'd0;
    cur_xdir = 1'b0;
    cur_ydir = 1'b0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      cur_x    = cur_x | (x_q[i] & {10{k_q == 3'(i)}});
      cur_y    = cur_y | (y_q[i] & {10{k_q == 3'(i)}});
      cur_xdir = cur_xdir | (xdir_q[i] & (k_q == 3'(i)));
      cur_ydir = cur_ydir | (ydir_q[i] & (k_q == 3'(i)));
    end
  end

  ball_axis_step #(.LIMIT(H_ACTIVE), .RADIUS(RADIUS)) u_step_x (
    .pos      (cur_x),
    .dir      (cur_xdir),
    .step     (step_q),
    .pos_next (nx),
    .dir_next (nxdir),
    .reflect  (refl_x)
  );

  ball_axis_step #(.LIMIT(V_ACTIVE), .RADIUS(RADIUS)) u_step_y (
    .pos      (cur_y),
    .dir      (cur_ydir),
    .step     (step_q),
    .pos_next (ny),
    .dir_next (nydir),
    .reflect  (refl_y)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    step_d   = step_q;
    bounce_d = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    xdir_d   = xdir_q;
    ydir_d   = ydir_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick && !pause) begin
          state_d = ST_UPDATE;
          k_d     = 3'd0;
          step_d  = {1'b0, speed_sel} + 3'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        for (int i = 0; i < NUM_BALLS; i++) begin
          if (k_q == 3'(i)) begin
            x_d[i]    = nx;
            y_d[i]    = ny;
            xdir_d[i] = nxdir;
            ydir_d[i] = nydir;
          end else begin
            x_d[i]    = x_q[i];
            y_d[i]    = y_q[i];
            xdir_d[i] = xdir_q[i];
            ydir_d[i] = ydir_q[i];
          end
        end
        bounce_d = refl_x | refl_y;
        if (k_q == LAST_K) begin
          state_d = ST_IDLE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_UPDATE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      k_q      <= 3'd0;
      step_q   <= 3'd1;
      bounce_q <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        x_q[i]    <= init_x(i);
        y_q[i]    <= init_y(i);
        xdir_q[i] <= init_xdir(i);
        ydir_q[i] <= init_ydir(i);
      end
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      step_q   <= step_d;
      bounce_q <= bounce_d;
      busy_q   <= busy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xdir_q   <= xdir_d;
      ydir_q   <= ydir_d;
    end
  end

  logic [NUM_BALLS-1:0][20:0] d2_q, d2_d;
  logic                       don_q, don_d;
  logic [5:0]                 rgb_q, rgb_d;
  logic                       hit_any;
  logic [5:0]                 ball_rgb;

  always_comb begin
    don_d = display_on;
    for (int i = 0; i < NUM_BALLS; i++) begin
      d2_d[i] = dist2(hpos, vpos, x_q[i], y_q[i]);
    end
  end

  // Scanning from the highest index down leaves the lowest hit ball's colour.
  always_comb begin
    hit_any  = 1'b0;
    ball_rgb = BG_RGB;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      hit_any  = hit_any | (d2_q[i] <= R2);
      ball_rgb = (d2_q[i] <= R2) ? palette_rgb(3'(i)) : ball_rgb;
    end
  end

`ifdef VGA_BALL_SHADOW_EN
  localparam int          RING_R = RADIUS + SHADOW_W;
  localparam logic [20:0] S2     = 21'(RING_R * RING_R);

  logic shadow_any;

  always_comb begin
    shadow_any = 1'b0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      shadow_any = shadow_any | (d2_q[i] <= S2);
    end
  end
`endif

  always_comb begin
    if (!don_q) begin
      rgb_d = 6'd0;
    end else if (hit_any) begin
      rgb_d = ball_rgb;
`ifdef VGA_BALL_SHADOW_EN
    end else if (shadow_any) begin
      rgb_d = SHADOW_RGB;
`endif
    end else begin
      rgb_d = BG_RGB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d2_q  <= '0;
      don_q <= 1'b0;
      rgb_q <= 6'd0;
    end else begin
      d2_q  <= d2_d;
      don_q <= don_d;
      rgb_q <= rgb_d;
    end
  end

  assign rgb    = rgb_q;
  assign bounce = bounce_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_vga_ball_field.sv
// Directed, scoreboard-based bench for vga_ball_field: a 4-ball and a 1-ball instance share stimulus.
module tb_vga_ball_field;

  localparam logic [5:0] C0 = 6'b11_10_00;
  localparam logic [5:0] C1 = 6'b11_00_00;
  localparam logic [5:0] C2 = 6'b00_11_00;
  localparam logic [5:0] BG = 6'b00_00_10;
`ifdef VGA_BALL_SHADOW_EN
  localparam logic [5:0] RING = 6'b01_01_01;
`else
  localparam logic [5:0] RING = 6'b00_00_10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] speed_sel = 2'd0;
  logic [9:0] hpos = 10'd0;
  logic [9:0] vpos = 10'd0;
  logic       display_on = 1'b0;

  logic [5:0] rgb4, rgb1;
  logic       bounce4, bounce1, busy4, busy1;

  int checks = 0;
  int errors = 0;

  // Each entry: {check4, exp4[5:0], check1, exp1[5:0]}
  logic [13:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  vga_ball_field #(.NUM_BALLS(4)) u_dut4 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pause(pause),
    .speed_sel(speed_sel), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .rgb(rgb4), .bounce(bounce4), .busy(busy4)
  );

  vga_ball_field #(.NUM_BALLS(1)) u_dut1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pause(pause),
    .speed_sel(speed_sel), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .rgb(rgb1), .bounce(bounce1), .busy(busy1)
  );

  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one pixel, queue its expectation, advance a cycle, then score the pixel from two cycles ago.
  task automatic cyc(input logic [9:0] hx, input logic [9:0] vy, input logic don, input string tag,
                     input logic c4, input logic [5:0] e4, input logic c1, input logic [5:0] e1);
    logic [13:0] e;
    string       t;
    hpos = hx;
    vpos = vy;
    display_on = don;
    exp_q.push_back({c4, e4, c1, e1});
    tag_q.push_back(tag);
    @(negedge clk);
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e[13]) chk6({t, "_rgb4"}, rgb4, e[12:7]);
      if (e[6])  chk6({t, "_rgb1"}, rgb1, e[5:0]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(10'd0, 10'd0, 1'b0, "idle", 1'b0, 6'd0, 1'b0, 6'd0);
  endtask

  task automatic probe(input logic [9:0] hx, input logic [9:0] vy, input string tag,
                       input logic [5:0] e4, input logic [5:0] e1);
    cyc(hx, vy, 1'b1, tag, 1'b1, e4, 1'b1, e1);
  endtask

  task automatic probe1(input logic [9:0] hx, input logic [9:0] vy, input string tag,
                        input logic [5:0] e1);
    cyc(hx, vy, 1'b1, tag, 1'b0, 6'd0, 1'b1, e1);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    idle(1);
    frame_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    chk6("rst_rgb4", rgb4, 6'd0);
    chk6("rst_rgb1", rgb1, 6'd0);
    chk1("rst_busy4", busy4, 1'b0);
    chk1("rst_busy1", busy1, 1'b0);
    chk1("rst_bounce4", bounce4, 1'b0);
    chk1("rst_bounce1", bounce1, 1'b0);

    // Reset positions: ball0 (160,120), ball1 (224,168), ball2 (288,216)
    probe(10'd160, 10'd120, "px_center", C0, C0);
    cyc(10'd160, 10'd120, 1'b0, "px_blank", 1'b1, 6'd0, 1'b1, 6'd0);
    probe(10'd180, 10'd120, "px_edge", C0, C0);
    probe(10'd181, 10'd120, "px_ring441", RING, RING);
    probe(10'd182, 10'd120, "px_ring484", RING, RING);
    probe(10'd185, 10'd120, "px_outside", BG, BG);
    probe(10'd224, 10'd168, "px_ball1", C1, BG);
    probe(10'd288, 10'd216, "px_ball2", C2, BG);
    idle(2);

    // One update at step 2
    speed_sel = 2'd1;
    pulse_tick();
    chk1("upd_busy1_hi", busy1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      chk1("upd_busy4_hi", busy4, 1'b1);
      chk1("upd_bounce4", bounce4, 1'b0);
      idle(1);
    end
    chk1("upd_busy4_lo", busy4, 1'b0);
    chk1("upd_busy1_lo", busy1, 1'b0);
    chk1("upd_bounce4_end", bounce4, 1'b0);
    probe(10'd162, 10'd122, "upd_b0_ctr", C0, C0);
    probe(10'd182, 10'd122, "upd_b0_xedge", C0, C0);
    probe(10'd183, 10'd122, "upd_b0_xout", RING, RING);
    probe(10'd162, 10'd142, "upd_b0_yedge", C0, C0);
    probe(10'd162, 10'd143, "upd_b0_yout", RING, RING);
    probe(10'd202, 10'd170, "upd_b1_xedge", C1, BG);
    probe(10'd201, 10'd170, "upd_b1_xout", RING, BG);
    probe(10'd222, 10'd190, "upd_b1_yedge", C1, BG);
    probe(10'd222, 10'd191, "upd_b1_yout", RING, BG);
    idle(2);

    // Paused tick is ignored
    pause = 1'b1;
    pulse_tick();
    chk1("pz_busy4_a", busy4, 1'b0);
    chk1("pz_busy1_a", busy1, 1'b0);
    idle(1);
    chk1("pz_busy4_b", busy4, 1'b0);
    pause = 1'b0;
    probe(10'd182, 10'd122, "pz_b0_edge", C0, C0);
    probe(10'd183, 10'd122, "pz_b0_out", RING, RING);
    idle(2);

    // Second tick while busy must not extend or restart the update
    speed_sel = 2'd0;
    pulse_tick();
    frame_tick = 1'b1;
    idle(1);
    frame_tick = 1'b0;
    chk1("dt_busy4_n2", busy4, 1'b1);
    chk1("dt_busy1_n2", busy1, 1'b0);
    idle(1);
    chk1("dt_busy4_n3", busy4, 1'b1);
    chk1("dt_busy1_n3", busy1, 1'b0);
    idle(1);
    chk1("dt_busy4_n4", busy4, 1'b1);
    idle(1);
    chk1("dt_busy4_n5", busy4, 1'b0);
    idle(1);
    chk1("dt_busy4_n6", busy4, 1'b0);
    probe(10'd183, 10'd123, "dt_b0_edge", C0, C0);
    probe(10'd184, 10'd123, "dt_b0_out", RING, RING);
    probe(10'd201, 10'd171, "dt_b1_edge", C1, BG);
    probe(10'd200, 10'd171, "dt_b1_out", RING, BG);
    idle(2);

    // Reset in the middle of an update
    speed_sel = 2'd3;
    pulse_tick();
    idle(1);
    reset = 1'b1;
    idle(1);
    chk1("rr_busy4_in_rst", busy4, 1'b0);
    reset = 1'b0;
    idle(1);
    chk1("rr_busy4_after", busy4, 1'b0);
    probe(10'd180, 10'd120, "rr_b0_edge", C0, C0);
    probe(10'd181, 10'd120, "rr_b0_out", RING, RING);
    probe(10'd204, 10'd168, "rr_b1_edge", C1, BG);
    probe(10'd203, 10'd168, "rr_b1_out", RING, BG);
    idle(2);

    // Bounce run on the single-ball instance, step 4
    for (int f = 1; f <= 115; f++) begin
      pulse_tick();
      chk1("bnc_busy1", busy1, 1'b1);
      idle(1);
      chk1("bnc_pulse", bounce1, (f == 85 || f == 115));
      idle(1);
      chk1("bnc_single", bounce1, 1'b0);
      idle(2);
      if (f == 85) begin
        probe1(10'd500, 10'd479, "bnc85_yedge", C0);
        probe1(10'd500, 10'd480, "bnc85_yout", RING);
        idle(2);
      end
    end
    probe1(10'd639, 10'd339, "bnc115_xedge", C0);
    probe1(10'd640, 10'd339, "bnc115_xout", RING);
    probe1(10'd619, 10'd319, "bnc115_yedge", C0);
    probe1(10'd619, 10'd318, "bnc115_yout", RING);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
